// File: rtl/memory_access.sv
// Memory-access pipeline stage: turns EX/MEM loads and stores into a
// req/ack data-memory transaction, formats load data, and feeds the
// MEM/WB pipeline register. Misaligned accesses never reach memory.
module memory_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic [31:0] EM_IR,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  write_addr_in,
    input  logic        wb_we_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] MW_IR,
    output logic [31:0] write_data_out,
    output logic [4:0]  write_addr_out,
    output logic        wb_we_out,
    output logic        stall_out,
    output logic        misalign
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    state_t      state;
    logic        is_load, is_store, sign_ld, unaligned, misaligned, aligned_mem;
    logic [1:0]  size;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic        acc_load, acc_signed;
    logic [1:0]  acc_size, acc_off;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_fmt, load_data;

    // Opcode decode and alignment check of the instruction sitting in EX/MEM
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sign_ld  = 1'b0;
        size     = SZ_WORD;
        case (EM_IR[31:26])
            OP_LB:  begin is_load = 1'b1;  size = SZ_BYTE; sign_ld = 1'b1; end
            OP_LH:  begin is_load = 1'b1;  size = SZ_HALF; sign_ld = 1'b1; end
            OP_LW:  begin is_load = 1'b1;  size = SZ_WORD; end
            OP_LBU: begin is_load = 1'b1;  size = SZ_BYTE; end
            OP_LHU: begin is_load = 1'b1;  size = SZ_HALF; end
            OP_SB:  begin is_store = 1'b1; size = SZ_BYTE; end
            OP_SH:  begin is_store = 1'b1; size = SZ_HALF; end
            OP_SW:  begin is_store = 1'b1; size = SZ_WORD; end
            default: ;
        endcase
        unaligned   = ((size == SZ_HALF) && alu_result[0]) ||
                      ((size == SZ_WORD) && (alu_result[1:0] != 2'b00));
        misaligned  = (is_load || is_store) && unaligned;
        aligned_mem = (is_load || is_store) && !unaligned;
    end

    // Little-endian byte enables and lane-replicated store data for the new access
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = store_data;
        case (size)
            SZ_BYTE: begin
                be_next    = 4'b0001 << alu_result[1:0];
                wdata_next = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                be_next    = alu_result[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Select and extend the addressed lane of the returning load word
    always_comb begin
        case (acc_off)
            2'd0:    sel_byte = mem_rdata[7:0];
            2'd1:    sel_byte = mem_rdata[15:8];
            2'd2:    sel_byte = mem_rdata[23:16];
            default: sel_byte = mem_rdata[31:24];
        endcase
        sel_half = acc_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (acc_size)
            SZ_BYTE: load_fmt = {{24{acc_signed & sel_byte[7]}}, sel_byte};
            SZ_HALF: load_fmt = {{16{acc_signed & sel_half[15]}}, sel_half};
            default: load_fmt = mem_rdata;
        endcase
    end

    // Upstream must hold while an access is pending or being issued
    assign stall_out = (state == ACCESS) || ((state == IDLE) && aligned_mem);

    // Access FSM together with the memory port and MEM/WB registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_be         <= '0;
            mem_wdata      <= '0;
            MW_IR          <= '0;
            write_data_out <= '0;
            write_addr_out <= '0;
            wb_we_out      <= 1'b0;
            misalign       <= 1'b0;
            acc_load       <= 1'b0;
            acc_signed     <= 1'b0;
            acc_size       <= SZ_WORD;
            acc_off        <= '0;
            load_data      <= '0;
        end else begin
            misalign <= 1'b0;
            case (state)
                IDLE: begin
                    if (!stall_in) begin
                        if (aligned_mem) begin
                            state      <= ACCESS;
                            mem_req    <= 1'b1;
                            mem_we     <= is_store;
                            mem_addr   <= {alu_result[31:2], 2'b00};
                            mem_be     <= be_next;
                            mem_wdata  <= wdata_next;
                            acc_load   <= is_load;
                            acc_signed <= sign_ld;
                            acc_size   <= size;
                            acc_off    <= alu_result[1:0];
                        end else begin
                            MW_IR          <= EM_IR;
                            write_data_out <= alu_result;
                            write_addr_out <= write_addr_in;
                            wb_we_out      <= wb_we_in & ~misaligned;
                            misalign       <= misaligned;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        load_data <= load_fmt;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (!stall_in) begin
                        MW_IR          <= EM_IR;
                        write_data_out <= acc_load ? load_data : alu_result;
                        write_addr_out <= write_addr_in;
                        wb_we_out      <= acc_load & wb_we_in;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: a table of directed vectors, a
// randomized run scored by an arithmetic reference model, and hand-written
// reset-during-access and startup sequences.
module tb_memory_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_in;
    logic [31:0] EM_IR, alu_result, store_data;
    logic [4:0]  write_addr_in;
    logic        wb_we_in;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] MW_IR, write_data_out;
    logic [4:0]  write_addr_out;
    logic        wb_we_out, stall_out, misalign;

    int checks = 0;
    int errors = 0;

    // Expected MEM/WB contents, advanced only when the bench expects a load
    logic [31:0] mwIr, mwWd;
    logic [4:0]  mwWa;
    logic        mwWe;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [31:0] addr, sdata, rdata;
        logic [4:0]  waddr;
        logic        wbwe;
        int          ackDelay, doneStall, preStall;
        logic [31:0] expWd;
        logic        expWbWe, expMis, memOp, storeOp;
        logic [3:0]  expBe;
        logic [31:0] expMemWd;
    } vec_t;

    memory_access dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .EM_IR(EM_IR),
        .alu_result(alu_result), .store_data(store_data),
        .write_addr_in(write_addr_in), .wb_we_in(wb_we_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .MW_IR(MW_IR), .write_data_out(write_data_out),
        .write_addr_out(write_addr_out), .wb_we_out(wb_we_out),
        .stall_out(stall_out), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkMw(input string name);
        checkOutput({name, " MW_IR"}, MW_IR, mwIr);
        checkOutput({name, " write_data_out"}, write_data_out, mwWd);
        checkOutput({name, " write_addr_out"}, {27'd0, write_addr_out}, {27'd0, mwWa});
        checkOutput({name, " wb_we_out"}, {31'd0, wb_we_out}, {31'd0, mwWe});
    endtask

    function automatic vec_t mk(string name, logic [5:0] op, logic [31:0] addr, logic [31:0] sdata,
                                logic [31:0] rdata, logic [4:0] waddr, logic wbwe, int ackD, int doneS,
                                int preS, logic [31:0] expWd, logic expWbWe, logic expMis,
                                logic memOp, logic storeOp, logic [3:0] expBe, logic [31:0] expMemWd);
        vec_t v;
        v.name = name; v.op = op; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
        v.waddr = waddr; v.wbwe = wbwe; v.ackDelay = ackD; v.doneStall = doneS; v.preStall = preS;
        v.expWd = expWd; v.expWbWe = expWbWe; v.expMis = expMis; v.memOp = memOp;
        v.storeOp = storeOp; v.expBe = expBe; v.expMemWd = expMemWd;
        return v;
    endfunction

    // Reference model: access width in bytes, alignment by modulo, lanes by shifting
    function automatic vec_t modelVec(string name, logic [5:0] op, logic [31:0] addr, logic [31:0] sdata,
                                      logic [31:0] rdata, logic [4:0] waddr, logic wbwe,
                                      int ackD, int doneS, int preS);
        int          n;
        int          off;
        bit          ld, st, sgn, mis, memOp;
        logic [31:0] mask, val, mwd;
        n = 0; ld = 0; st = 0; sgn = 0;
        case (op)
            6'h20: begin n = 1; ld = 1; sgn = 1; end
            6'h21: begin n = 2; ld = 1; sgn = 1; end
            6'h23: begin n = 4; ld = 1; end
            6'h24: begin n = 1; ld = 1; end
            6'h25: begin n = 2; ld = 1; end
            6'h28: begin n = 1; st = 1; end
            6'h29: begin n = 2; st = 1; end
            6'h2B: begin n = 4; st = 1; end
            default: ;
        endcase
        off   = int'(addr % 4);
        mis   = (n != 0) && ((addr % n) != 0);
        memOp = (n != 0) && !mis;
        mask  = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
        val   = (rdata >> (8 * off)) & mask;
        if (sgn && val[8 * n - 1]) val = val | ~mask;
        if (n == 1)      mwd = {24'd0, sdata[7:0]} * 32'h0101_0101;
        else if (n == 2) mwd = {16'd0, sdata[15:0]} * 32'h0001_0001;
        else             mwd = sdata;
        return mk(name, op, addr, sdata, rdata, waddr, wbwe, ackD, doneS, preS,
                  (memOp && ld) ? val : addr,
                  (memOp && ld) ? wbwe : ((n != 0) ? 1'b0 : wbwe),
                  mis, memOp, st, 4'(((1 << n) - 1) << off), mwd);
    endfunction

    // Drive one instruction through the stage and check every phase of it
    task automatic applyStimulus(input vec_t v);
        logic [31:0] ir;
        ir = {v.op, 26'($urandom)};
        EM_IR = ir; alu_result = v.addr; store_data = v.sdata;
        write_addr_in = v.waddr; wb_we_in = v.wbwe;
        mem_rdata = ~v.rdata;
        stall_in = 1'b1; mem_ack = 1'b1;
        for (int i = 0; i < v.preStall; i++) begin
            @(posedge clk); #1;
            checkOutput({v.name, " held mem_req"}, {31'd0, mem_req}, 32'd0);
            checkMw({v.name, " held"});
        end
        mem_ack = 1'b0; stall_in = 1'b0; #1;
        checkOutput({v.name, " stall_out idle"}, {31'd0, stall_out}, {31'd0, v.memOp});
        @(posedge clk); #1;
        if (v.memOp) begin
            checkOutput({v.name, " mem_req"}, {31'd0, mem_req}, 32'd1);
            checkOutput({v.name, " mem_we"}, {31'd0, mem_we}, {31'd0, v.storeOp});
            checkOutput({v.name, " mem_addr"}, mem_addr, v.addr & 32'hFFFF_FFFC);
            checkOutput({v.name, " mem_be"}, {28'd0, mem_be}, {28'd0, v.expBe});
            if (v.storeOp) checkOutput({v.name, " mem_wdata"}, mem_wdata, v.expMemWd);
            checkOutput({v.name, " stall_out access"}, {31'd0, stall_out}, 32'd1);
            checkMw({v.name, " access"});
            for (int i = 0; i < v.ackDelay; i++) begin
                stall_in = 1'(i % 2);
                @(posedge clk); #1;
                checkOutput({v.name, " wait mem_req"}, {31'd0, mem_req}, 32'd1);
                checkOutput({v.name, " wait mem_addr"}, mem_addr, v.addr & 32'hFFFF_FFFC);
                checkOutput({v.name, " wait stall_out"}, {31'd0, stall_out}, 32'd1);
            end
            stall_in = 1'b0; mem_ack = 1'b1; mem_rdata = v.rdata;
            @(posedge clk); #1;
            mem_ack = 1'b0; mem_rdata = ~v.rdata;
            checkOutput({v.name, " done mem_req"}, {31'd0, mem_req}, 32'd0);
            checkOutput({v.name, " done stall_out"}, {31'd0, stall_out}, 32'd0);
            checkMw({v.name, " done"});
            stall_in = 1'b1; mem_ack = 1'b1;
            for (int i = 0; i < v.doneStall; i++) begin
                @(posedge clk); #1;
                checkOutput({v.name, " done-hold stall_out"}, {31'd0, stall_out}, 32'd0);
                checkMw({v.name, " done-hold"});
            end
            mem_ack = 1'b0; stall_in = 1'b0;
            @(posedge clk); #1;
        end
        mwIr = ir; mwWd = v.expWd; mwWa = v.waddr; mwWe = v.expWbWe;
        checkMw({v.name, " wb"});
        checkOutput({v.name, " misalign"}, {31'd0, misalign}, {31'd0, v.expMis});
        stall_in = 1'b1;
        @(posedge clk); #1;
        checkOutput({v.name, " misalign clear"}, {31'd0, misalign}, 32'd0);
        checkOutput({v.name, " after mem_req"}, {31'd0, mem_req}, 32'd0);
        checkMw({v.name, " after"});
    endtask

    vec_t table_v[$];
    logic [5:0] randOps [10] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h00, 6'h0F};

    initial begin
        rst = 1'b1; stall_in = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        EM_IR = '0; alu_result = '0; store_data = '0; write_addr_in = '0; wb_we_in = 1'b0;
        mwIr = '0; mwWd = '0; mwWa = '0; mwWe = 1'b0;

        table_v.push_back(mk("ADD",     6'h00, 32'h1234, 32'h0, 32'h0, 5'd5, 1'b1, 0, 0, 0, 32'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0));
        table_v.push_back(mk("LB",      6'h20, 32'h103, 32'h0, 32'h80FF_FFFF, 5'd6, 1'b1, 1, 0, 0, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1000, 32'h0));
        table_v.push_back(mk("LBU",     6'h24, 32'h103, 32'h0, 32'h80FF_FFFF, 5'd7, 1'b1, 1, 0, 1, 32'h0000_0080, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1000, 32'h0));
        table_v.push_back(mk("SH",      6'h29, 32'h202, 32'hABCD_1234, 32'h0, 5'd8, 1'b1, 0, 0, 0, 32'h202, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1100, 32'h1234_1234));
        table_v.push_back(mk("LW-mis",  6'h23, 32'h101, 32'h0, 32'h0, 5'd9, 1'b1, 0, 0, 0, 32'h101, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0));
        table_v.push_back(mk("LH",      6'h21, 32'h102, 32'h0, 32'h8001_1234, 5'd10, 1'b1, 0, 1, 0, 32'hFFFF_8001, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1100, 32'h0));
        table_v.push_back(mk("LHU",     6'h25, 32'h100, 32'h0, 32'h0000_F00D, 5'd11, 1'b1, 2, 0, 0, 32'h0000_F00D, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0011, 32'h0));
        table_v.push_back(mk("SW",      6'h2B, 32'h300, 32'hDEAD_BEEF, 32'h0, 5'd12, 1'b1, 0, 3, 0, 32'h300, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 32'hDEAD_BEEF));
        table_v.push_back(mk("SB",      6'h28, 32'h401, 32'h0000_00A5, 32'h0, 5'd13, 1'b1, 0, 0, 0, 32'h401, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0010, 32'hA5A5_A5A5));
        table_v.push_back(mk("SH-mis",  6'h29, 32'h203, 32'h1, 32'h0, 5'd14, 1'b1, 0, 0, 0, 32'h203, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0));
        table_v.push_back(mk("LW",      6'h23, 32'h104, 32'h0, 32'h1357_2468, 5'd15, 1'b1, 0, 0, 0, 32'h1357_2468, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1111, 32'h0));

        // Outputs must already be zero while reset is held
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("reset mem_be", {28'd0, mem_be}, 32'd0);
        checkOutput("reset mem_addr", mem_addr, 32'd0);
        checkOutput("reset misalign", {31'd0, misalign}, 32'd0);
        checkMw("reset");
        rst = 1'b0;

        foreach (table_v[i]) applyStimulus(table_v[i]);

        // Randomized instructions scored by the reference model
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = $urandom;
            applyStimulus(modelVec($sformatf("rand%0d", i), randOps[$urandom_range(0, 9)], a,
                                   $urandom, $urandom, 5'($urandom), 1'($urandom),
                                   $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 1)));
        end

        // Reset in the middle of an access abandons it; a late ack does nothing
        EM_IR = {6'h23, 26'h0}; alu_result = 32'h500; stall_in = 1'b0; mem_ack = 1'b0;
        @(posedge clk); #1;
        checkOutput("rstacc mem_req before", {31'd0, mem_req}, 32'd1);
        #2 rst = 1'b1;
        EM_IR = '0;
        #1;
        checkOutput("rstacc mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("rstacc mem_we", {31'd0, mem_we}, 32'd0);
        checkOutput("rstacc mem_be", {28'd0, mem_be}, 32'd0);
        checkOutput("rstacc mem_addr", mem_addr, 32'd0);
        checkOutput("rstacc mem_wdata", mem_wdata, 32'd0);
        checkOutput("rstacc stall_out", {31'd0, stall_out}, 32'd0);
        mwIr = '0; mwWd = '0; mwWa = '0; mwWe = 1'b0;
        checkMw("rstacc");
        @(negedge clk);
        rst = 1'b0; stall_in = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        repeat (2) @(posedge clk);
        #1;
        mem_ack = 1'b0;
        checkOutput("rstacc late-ack mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("rstacc late-ack stall_out", {31'd0, stall_out}, 32'd0);
        checkMw("rstacc late-ack");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  CPU clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 stall_in  input  1  global freeze; 1 = hold the MW outputs and do not start new accesses.
REQ-005 EM_IR  input  32  instruction in the EX/MEM pipeline register.
REQ-006 alu_result  input  32  effective address for loads/stores; result for other instructions.
REQ-007 store_data  input  32  rt value for stores.
REQ-008 write_addr_in  input  5  destination register.
REQ-009 wb_we_in  input  1  register write enable from decode.
REQ-010 mem_req  output  1  data-memory request, registered.
REQ-011 mem_we  output  1  1 = store, 0 = load; valid while mem_req=1.
REQ-012 mem_addr  output  32  word address {alu_result[31:2],2'b00}.
REQ-013 mem_be  output  4  byte enables; bit n selects data bits 8n+7:8n.
REQ-014 mem_wdata  output  32  store data, lane-replicated.
REQ-015 mem_ack  input  1  memory completion, sampled at posedge while mem_req=1.
REQ-016 mem_rdata  input  32  load data, valid when mem_ack=1.
REQ-017 MW_IR, write_data_out, write_addr_out, wb_we_out  outputs  32/32/5/1  MEM/WB pipeline register feeding write-back.
REQ-018 stall_out  output  1  combinational; 1 = upstream stages must hold.
REQ-019 misalign  output  1  one-cycle pulse on a misaligned access.

Function
REQ-020 Decode EM_IR[31:26]: LB=0x20, LH=0x21, LW=0x23, LBU=0x24, LHU=0x25, SB=0x28, SH=0x29, SW=0x2B; every other opcode is a non-memory opcode.
REQ-021 Byte lanes are little-endian: addr[1:0]=0 selects bits 7:0.
REQ-022 Misaligned = LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0; treat a misaligned access as non-memory, force wb_we_out=0, and pulse misalign for the cycle of the MW load.
REQ-023 FSM states are IDLE, ACCESS and DONE.
REQ-024 IDLE + aligned memory op: stall_out=1; at the next edge with stall_in=0, go to ACCESS, set mem_req=1, and drive mem_we/mem_addr/mem_be/mem_wdata.
REQ-025 IDLE + non-memory op: stall_out=0; at each edge with stall_in=0, load MW_IR<=EM_IR, write_data_out<=alu_result, write_addr_out<=write_addr_in, wb_we_out<=wb_we_in.
REQ-026 ACCESS: stall_out=1; mem_* outputs stay stable; at the edge with mem_ack=1, clear mem_req, capture the formatted load data, and go to DONE; ignore stall_in.
REQ-027 DONE: stall_out=0; at the edge with stall_in=0, load the MW registers (write_data_out = captured load data, or alu_result for stores) and go to IDLE; if stall_in=1, hold DONE.
REQ-028 Load formatting: LB/LH sign-extend and LBU/LHU zero-extend the selected byte/halfword; LW passes the word through.
REQ-029 Stores: wb_we_out=0. SB: mem_be=1<<addr[1:0], mem_wdata={4{byte}}. SH: mem_be=addr[1]?4'b1100:4'b0011, mem_wdata={2{half}}. SW: mem_be=4'b1111.
REQ-030 Minimum load/store latency is 3 edges: IDLE->ACCESS, ack->DONE, DONE->MW load; each wait cycle before mem_ack adds 1.
REQ-031 Ignore mem_ack outside ACCESS.
REQ-032 While stall_in=1, hold every MW output unchanged.

Reset
REQ-033 With rst=1, the block SHALL immediately force state=IDLE, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, MW_IR=0, write_data_out=0, write_addr_out=0, wb_we_out=0, misalign=0.
REQ-034 Reset during ACCESS SHALL abandon the access, with mem_req low in the same cycle; a later mem_ack SHALL have no effect.

Verification
REQ-035 ADD with alu_result=0x1234, write_addr_in=5, wb_we_in=1 -> after 1 edge: write_data_out=0x1234, write_addr_out=5, wb_we_out=1, stall_out=0 throughout.
REQ-036 LB at addr 0x103, mem_rdata=0x80FFFFFF, ack 2 cycles after req -> mem_be=4'b1000, stall_out=1 for 3 cycles, write_data_out=0xFFFFFF80; LBU on the same data gives 0x00000080.
REQ-037 SH at addr 0x202, store_data=0xABCD1234 -> mem_we=1, mem_be=4'b1100, mem_wdata=0x12341234, wb_we_out=0.
REQ-038 LW at addr 0x101 -> no mem_req, misalign pulses 1 cycle, wb_we_out=0.
REQ-039 rst asserted in ACCESS, then ack asserted -> mem_req=0 immediately, state IDLE, all outputs 0, no MW update.
REQ-040 stall_in=1 while in DONE for 3 cycles -> MW outputs held, state DONE; the MW update occurs on the first edge with stall_in=0.
